// File: rtl/pulse_meas_pkg.sv
// Shared encodings and helpers for the pulse width meter.
package pulse_meas_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] WAIT_RISE = 2'd1;
    localparam logic [STATE_W-1:0] MEASURE   = 2'd2;

    localparam logic MODE_HIGH   = 1'b0;
    localparam logic MODE_PERIOD = 1'b1;

    // Largest count representable in n bits (2**n - 1), limited to 32 bits.
    function automatic logic [31:0] sat_value(input int unsigned n);
        if (n >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain for an asynchronous input plus registered edge detection.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the async input through the chain and flag level changes of s.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
            rise   <= s & ~s_d;
            fall   <= ~s & s_d;
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high-pulse width or period of an async signal in clk cycles.
module pulse_width_meter
    import pulse_meas_pkg::*;
#(
    parameter int unsigned N           = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic         mode,
    input  logic         sig_in,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [N-1:0] width
);

    localparam logic [N-1:0] CNT_MAX = N'(sat_value(N));

    logic [STATE_W-1:0] state_q, state_d;
    logic [N-1:0]       cnt_q, cnt_d;
    logic [N-1:0]       width_d;
    logic               sat_q, sat_d;
    logic               ovf_d, done_d;
    logic               mode_q, mode_d;
    logic               rise, fall, end_edge;
    logic               s_unused;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .sig_in(sig_in),
        .s     (s_unused),
        .rise  (rise),
        .fall  (fall)
    );

    assign end_edge = (mode_q == MODE_PERIOD) ? rise : fall;

    // Next-state, counter and result logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        width_d = width;
        ovf_d   = ovf;
        done_d  = 1'b0;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mode_d  = mode;
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rise) begin
                    cnt_d   = N'(1);
                    sat_d   = 1'b0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (end_edge) begin
                    // Hitting the ceiling exactly on the end edge still counts as overflow.
                    width_d = cnt_q;
                    ovf_d   = sat_q | (cnt_q == CNT_MAX);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + N'(1);
                end else begin
                    sat_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            mode_q  <= 1'b0;
            width   <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            mode_q  <= mode_d;
            width   <= width_d;
            ovf     <= ovf_d;
            done    <= done_d;
            busy    <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench: N=16 and N=4 instances driven by the same stimulus.
module tb_pulse_width_meter;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int          LAT         = SYNC_STAGES + 2;

    logic        clk = 1'b0;
    logic        reset, start, abort, mode, sig_in;
    logic        busy16, done16, ovf16;
    logic [15:0] width16;
    logic        busy4, done4, ovf4;
    logic [3:0]  width4;

    int n_checks   = 0;
    int n_errors   = 0;
    int done_cnt16 = 0;
    int done_cnt4  = 0;

    always #5 clk = ~clk;

    pulse_width_meter #(.N(16), .SYNC_STAGES(SYNC_STAGES)) dut16 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .sig_in(sig_in), .busy(busy16), .done(done16), .ovf(ovf16), .width(width16)
    );

    pulse_width_meter #(.N(4), .SYNC_STAGES(SYNC_STAGES)) dut4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .sig_in(sig_in), .busy(busy4), .done(done4), .ovf(ovf4), .width(width4)
    );

    // Count done strobes; a strobe lasting two cycles is counted twice.
    always @(posedge clk) begin
        if (done16) done_cnt16 <= done_cnt16 + 1;
        if (done4)  done_cnt4  <= done_cnt4 + 1;
    end

    // Reference: result is the raw cycle count clipped to 2**n-1; ovf when it reaches that ceiling.
    function automatic int unsigned model_width(input int unsigned raw, input int unsigned n);
        int unsigned mx;
        mx = (32'd1 << n) - 32'd1;
        return (raw > mx) ? mx : raw;
    endfunction

    function automatic bit model_ovf(input int unsigned raw, input int unsigned n);
        int unsigned mx;
        mx = (32'd1 << n) - 32'd1;
        return raw >= mx;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm(input bit m);
        start = 1'b1;
        mode  = m;
        cyc(1);
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            cyc(1);
            if (done16) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic measure(input bit m, input int h, input int l, input string tag);
        int          lat, base16, base4;
        int unsigned raw;
        base16 = done_cnt16;
        base4  = done_cnt4;
        arm(m);
        n_checks++;
        if (busy16 !== 1'b1 || busy4 !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_after_arm: got %b/%b want 1/1", tag, busy16, busy4);
        end
        cyc(3);
        sig_in = 1'b1;
        cyc(h);
        sig_in = 1'b0;
        if (m) begin
            cyc(l);
            sig_in = 1'b1;
        end
        wait_done(LAT + 8, lat);
        raw = m ? unsigned'(h + l) : unsigned'(h);
        n_checks++;
        if (lat !== LAT) begin
            n_errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, LAT);
        end
        n_checks++;
        if (done4 !== 1'b1) begin
            n_errors++;
            $display("FAIL %s done4: got %b want 1", tag, done4);
        end
        n_checks++;
        if (width16 !== 16'(model_width(raw, 16)) || ovf16 !== model_ovf(raw, 16)) begin
            n_errors++;
            $display("FAIL %s n16 result: got w=%0d ovf=%b want w=%0d ovf=%b", tag, width16, ovf16,
                     model_width(raw, 16), model_ovf(raw, 16));
        end
        n_checks++;
        if (width4 !== 4'(model_width(raw, 4)) || ovf4 !== model_ovf(raw, 4)) begin
            n_errors++;
            $display("FAIL %s n4 result: got w=%0d ovf=%b want w=%0d ovf=%b", tag, width4, ovf4,
                     model_width(raw, 4), model_ovf(raw, 4));
        end
        sig_in = 1'b0;
        cyc(LAT + 2);
        n_checks++;
        if (busy16 !== 1'b0 || done_cnt16 != base16 + 1 || done_cnt4 != base4 + 1) begin
            n_errors++;
            $display("FAIL %s after_done: got busy=%b dones=%0d/%0d want busy=0 dones=1/1", tag, busy16,
                     done_cnt16 - base16, done_cnt4 - base4);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; sig_in = 1'b0;
        cyc(3);
        n_checks++;
        if ({busy16, done16, ovf16, width16, busy4, done4, ovf4, width4} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%b done=%b ovf=%b w=%0d / busy=%b done=%b ovf=%b w=%0d want all 0",
                     busy16, done16, ovf16, width16, busy4, done4, ovf4, width4);
        end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_high_pulse();
        measure(1'b0, 37, 0, "high37");
    endtask

    task automatic test_period();
        measure(1'b1, 10, 15, "period25");
    endtask

    task automatic test_saturation();
        measure(1'b0, 40, 0, "sat40");
        measure(1'b0, 5, 0, "after_sat5");
        measure(1'b0, 15, 0, "edge15");
        measure(1'b0, 14, 0, "edge14");
    endtask

    task automatic test_abort_reset();
        int base;
        measure(1'b0, 10, 0, "abort_pre");
        base = done_cnt16;
        arm(1'b0);
        cyc(3);
        sig_in = 1'b1;
        cyc(LAT + 4);
        n_checks++;
        if (busy16 !== 1'b1) begin
            n_errors++;
            $display("FAIL abort busy_in_measure: got %b want 1", busy16);
        end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        n_checks++;
        if (busy16 !== 1'b0 || done16 !== 1'b0) begin
            n_errors++;
            $display("FAIL abort busy_drop: got busy=%b done=%b want 0/0", busy16, done16);
        end
        sig_in = 1'b0;
        cyc(LAT + 4);
        n_checks++;
        if (done_cnt16 != base || width16 !== 16'd10 || ovf16 !== 1'b0 || width4 !== 4'd10) begin
            n_errors++;
            $display("FAIL abort held: got dones=%0d w16=%0d ovf=%b w4=%0d want 0 10 0 10",
                     done_cnt16 - base, width16, ovf16, width4);
        end
        base = done_cnt16;
        arm(1'b0);
        cyc(3);
        sig_in = 1'b1;
        cyc(LAT + 4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        n_checks++;
        if ({busy16, done16, ovf16, width16, busy4, done4, ovf4, width4} !== '0) begin
            n_errors++;
            $display("FAIL midreset outputs: got busy=%b done=%b ovf=%b w=%0d w4=%0d want all 0",
                     busy16, done16, ovf16, width16, width4);
        end
        sig_in = 1'b0;
        cyc(LAT + 4);
        n_checks++;
        if (done_cnt16 != base || busy16 !== 1'b0 || width16 !== 16'd0) begin
            n_errors++;
            $display("FAIL midreset silent: got dones=%0d busy=%b w=%0d want 0 0 0",
                     done_cnt16 - base, busy16, width16);
        end
    endtask

    task automatic test_armed_high();
        int base, lat;
        base = done_cnt16;
        sig_in = 1'b1;
        cyc(5);
        arm(1'b0);
        cyc(14);
        sig_in = 1'b0;
        cyc(3);
        sig_in = 1'b1;
        cyc(6);
        sig_in = 1'b0;
        wait_done(LAT + 8, lat);
        n_checks++;
        if (lat !== LAT || width16 !== 16'd6 || ovf16 !== 1'b0 || width4 !== 4'd6) begin
            n_errors++;
            $display("FAIL armed_high: got lat=%0d w=%0d ovf=%b w4=%0d want %0d 6 0 6",
                     lat, width16, ovf16, width4, LAT);
        end
        cyc(LAT + 2);
        n_checks++;
        if (done_cnt16 != base + 1) begin
            n_errors++;
            $display("FAIL armed_high dones: got %0d want 1", done_cnt16 - base);
        end
    endtask

    task automatic test_start_abort();
        int base;
        base = done_cnt16;
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy16 !== 1'b0) begin
            n_errors++;
            $display("FAIL start_abort busy: got %b want 0", busy16);
        end
        sig_in = 1'b1;
        cyc(5);
        sig_in = 1'b0;
        cyc(LAT + 4);
        n_checks++;
        if (done_cnt16 != base) begin
            n_errors++;
            $display("FAIL start_abort dones: got %0d want 0", done_cnt16 - base);
        end
        arm(1'b0);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        n_checks++;
        if (busy16 !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_rise_abort busy: got %b want 0", busy16);
        end
    endtask

    task automatic test_back_to_back();
        int base, lat;
        base = done_cnt16;
        arm(1'b0);
        cyc(3);
        sig_in = 1'b1;
        cyc(8);
        sig_in = 1'b0;
        wait_done(LAT + 8, lat);
        n_checks++;
        if (lat !== LAT || width16 !== 16'd8) begin
            n_errors++;
            $display("FAIL b2b first: got lat=%0d w=%0d want %0d 8", lat, width16, LAT);
        end
        start = 1'b1;
        mode  = 1'b0;
        cyc(1);
        start = 1'b0;
        n_checks++;
        if (busy16 !== 1'b1 || width16 !== 16'd8 || done16 !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b rearm: got busy=%b w=%0d done=%b want 1 8 0", busy16, width16, done16);
        end
        cyc(2);
        sig_in = 1'b1;
        cyc(1);
        sig_in = 1'b0;
        wait_done(LAT + 8, lat);
        n_checks++;
        if (lat !== LAT || width16 !== 16'd1 || ovf16 !== 1'b0 || width4 !== 4'd1) begin
            n_errors++;
            $display("FAIL b2b short: got lat=%0d w=%0d ovf=%b w4=%0d want %0d 1 0 1",
                     lat, width16, ovf16, width4, LAT);
        end
        cyc(LAT + 2);
        n_checks++;
        if (done_cnt16 != base + 2) begin
            n_errors++;
            $display("FAIL b2b dones: got %0d want 2", done_cnt16 - base);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            bit m;
            int h, l;
            m = bit'($urandom_range(0, 1));
            h = int'($urandom_range(1, 40));
            l = int'($urandom_range(1, 30));
            measure(m, h, l, $sformatf("rand%0d_m%0d_h%0d_l%0d", k, m, h, l));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; sig_in = 1'b0;
        test_reset();
        test_high_pulse();
        test_period();
        test_saturation();
        test_abort_reset();
        test_armed_high();
        test_start_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
- Measures time on an external, asynchronous digital signal in clk cycles. Two modes: high-pulse width, or full period (rising edge to rising edge).
- This is the measuring end of our timing path: univ_cntr-based generators produce ticks and pulses, and this block reads them back as a count.
- Used for self-check of PWM and tick generators and for capturing external pulse timing. Results go to a register/CSR layer through a one-cycle done strobe.

Parameters:
- N, 16, width of the measurement counter and result, in bits.
- SYNC_STAGES, 2, number of synchronizer flops on sig_in. Minimum is 2.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle arm request. Ignored unless the block is idle.
- abort  input  1  cancels the measurement in progress. Returns to IDLE and no done is issued.
- mode  input  1  0 = high-pulse width (rise to fall), 1 = period (rise to rise). Sampled on start.
- sig_in  input  1  asynchronous signal to be measured.
- busy  output  1  high in WAIT_RISE and MEASURE.
- done  output  1  one-cycle strobe. width and ovf are valid in that cycle and hold afterwards.
- ovf  output  1  set when the last result saturated. Updated with done.
- width  output  N  last measured count in clk cycles. Held until the next done.

Behaviour:
- Reset: synchronous, active-high, with priority over everything else.
  - State goes to IDLE.
  - Synchronizer flops, previous-level flop, counter, width, ovf, done, busy and the latched mode all go to 0.
  - Reset asserted mid-measurement discards that measurement silently.
- Input conditioning:
  - sig_in passes through SYNC_STAGES flops to give s.
  - One more flop gives s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
- FSM states: IDLE, WAIT_RISE, MEASURE. Encodings are in the package.
  - IDLE: start=1 and abort=0 -> latch mode, go to WAIT_RISE. start and abort together -> stay IDLE.
  - WAIT_RISE: abort -> IDLE. rise -> MEASURE with cnt <= 1. Otherwise hold.
  - MEASURE: abort -> IDLE, cnt discarded.
    - End edge is fall in mode 0 and rise in mode 1.
    - On the end edge: width <= cnt, ovf <= sat, done <= 1 for the next cycle only, state goes to IDLE.
    - Otherwise: cnt <= cnt+1, saturating at 2**N-1. sat is set sticky once cnt reaches 2**N-1.
- Count semantics: rise detected in cycle t0 and end edge detected in cycle t1 gives width = t1 - t0.
  - A one-cycle synchronized pulse gives width = 1.
- Saturation:
  - The counter never wraps.
  - A result of 2**N-1 with sat=1 reports ovf=1.
  - cnt of exactly 2**N-1 reached on the end-edge cycle still reports ovf=1.
- Latency: from the sig_in pin edge, done asserts SYNC_STAGES+2 cycles later.
- Signal already high when armed: no rise is seen, so the block waits for the next low-to-high transition.
- Re-arm: start in the same cycle as done is allowed, because the state is IDLE in that cycle. The old width holds until the new done.
- start while busy: ignored. mode changes while busy: ignored.
- done is never high in two consecutive cycles.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package pulse_meas_pkg holds the state encodings (IDLE=2'd0, WAIT_RISE=2'd1, MEASURE=2'd2), the mode constants MODE_HIGH=1'b0 and MODE_PERIOD=1'b1, and the saturation-value function.
- Sub-module sync_edge_det is parameterised by SYNC_STAGES. It provides the synchronizer chain plus the previous-level flop, with outputs s, rise and fall. It is reused elsewhere for async inputs.
- The FSM, counter and result registers stay in the top.

Test Plan:
- Mode 0, N=16: start, then sig_in high for 37 cycles, then low (clean, clk-aligned) -> done once, width=37, ovf=0. done appears SYNC_STAGES+2 cycles after the fall.
- Mode 1: start, then square wave with 10 cycles high and 15 low -> width=25 after the second rising edge. The first edge after arming starts the count.
- Saturation, N=4: mode 0, high pulse of 40 cycles -> width=15, ovf=1. Next measurement of a 5-cycle pulse -> width=5, ovf=0.
- Abort and reset: abort 5 cycles into MEASURE -> busy drops next cycle, no done, width unchanged. Repeat with reset in place of abort -> all outputs 0.
- Arm while sig_in is already high for 20 cycles, then low 3, then high 6 -> mode 0 reports width=6, not a partial pulse.
- start asserted with abort -> stays IDLE. start in the done cycle -> re-arms, and a back-to-back pulse of 1 synchronized cycle gives width=1.
